fetch_queue: RTL and testbench

- Dual-issue instruction fetch queue for the phase-4 superscalar core.
- Sits between the instruction memory fetch stage and the dual decode stage.
- Each cycle it accepts up to two {instruction, PC} pairs from fetch and presents up to two to decode, oldest first, in first-word-fall-through order.
- Decouples fetch stalls from decode stalls and drops all contents on a branch/jump flush.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the dual-issue fetch queue.
// master: the fetch and decode side that drives pushes and pops.
// slave:  the queue itself.
interface fetch_queue_if #(
  parameter int unsigned PTR_W = 3
);
  logic             flush;
  logic [1:0]       in_valid;
  logic [31:0]      in_instr0;
  logic [31:0]      in_pc0;
  logic [31:0]      in_instr1;
  logic [31:0]      in_pc1;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [31:0]      out_instr0;
  logic [31:0]      out_pc0;
  logic [31:0]      out_instr1;
  logic [31:0]      out_pc1;
  logic [1:0]       out_pop;
  logic [PTR_W:0]   count;

  modport master (
    output flush, in_valid, in_instr0, in_pc0, in_instr1, in_pc1, out_pop,
    input  in_ready, out_valid, out_instr0, out_pc0, out_instr1, out_pc1, count
  );

  modport slave (
    input  flush, in_valid, in_instr0, in_pc0, in_instr1, in_pc1, out_pop,
    output in_ready, out_valid, out_instr0, out_pc0, out_instr1, out_pc1, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue. Accepts up to two {instr, pc} pairs per
// cycle from fetch and presents the two oldest entries to decode in
// first-word-fall-through order. Flush drops all contents without clearing
// storage.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  fetch_queue_if.slave  bus
);

  // Push is only offered while at least two entries are free.
  localparam logic [PTR_W:0] PushMax = (PTR_W + 1)'(DEPTH - 2);
  localparam logic [PTR_W:0] One     = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] Two     = (PTR_W + 1)'(2);

  // Entry layout: {instr[63:32], pc[31:0]}.
  logic [63:0]      mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, head_p1;
  logic [PTR_W-1:0] tail_q, tail_d, tail_p1;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   n_push, n_pop;
  logic             ready;
  logic             we0, we1;
  logic [63:0]      entry0, entry1;

  // Neighbouring pointers; wrap falls out of the PTR_W-bit add.
  always_comb begin
    head_p1 = head_q + PTR_W'(1);
    tail_p1 = tail_q + PTR_W'(1);
  end

  // Decode push/pop requests; illegal or over-occupancy requests do nothing.
  always_comb begin
    ready  = (count_q <= PushMax);
    n_push = '0;
    n_pop  = '0;
    if (ready) begin
      case (bus.in_valid)
        2'b01:   n_push = One;
        2'b11:   n_push = Two;
        default: n_push = '0;
      endcase
    end
    case (bus.out_pop)
      2'b01:   n_pop = (count_q >= One) ? One : '0;
      2'b11:   n_pop = (count_q >= Two) ? Two : '0;
      default: n_pop = '0;
    endcase
  end

  // Next pointer/occupancy state and storage write enables; flush wins.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we0     = 1'b0;
    we1     = 1'b0;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + n_pop[PTR_W-1:0];
      tail_d  = tail_q + n_push[PTR_W-1:0];
      count_d = count_q + n_push - n_pop;
      we0     = (n_push != '0);
      we1     = (n_push == Two);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so unused read slots never show X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[PTR_W'(i)] <= '0;
      end
    end else begin
      if (we0) mem_q[tail_q]  <= {bus.in_instr0, bus.in_pc0};
      if (we1) mem_q[tail_p1] <= {bus.in_instr1, bus.in_pc1};
    end
  end

  // Read ports and status straight from registered state, no bypass.
  always_comb begin
    entry0         = mem_q[head_q];
    entry1         = mem_q[head_p1];
    bus.out_instr0 = entry0[63:32];
    bus.out_pc0    = entry0[31:0];
    bus.out_instr1 = entry1[63:32];
    bus.out_pc1    = entry1[31:0];
    bus.out_valid  = {count_q >= Two, count_q >= One};
    bus.in_ready   = ready;
    bus.count      = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH = 8).
module tb_fetch_queue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_queue_if #(.PTR_W(3)) bus ();

  fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc | 32'h1300_0000;
  endfunction

  task automatic idle();
    bus.flush     = 1'b0;
    bus.in_valid  = 2'b00;
    bus.in_instr0 = '0;
    bus.in_pc0    = '0;
    bus.in_instr1 = '0;
    bus.in_pc1    = '0;
    bus.out_pop   = 2'b00;
  endtask

  // Apply one cycle of stimulus, clock it in, sample 1 time unit later.
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl);
    bus.in_valid  = v;
    bus.in_pc0    = p0;
    bus.in_instr0 = ins(p0);
    bus.in_pc1    = p1;
    bus.in_instr1 = ins(p1);
    bus.out_pop   = pop;
    bus.flush     = fl;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_hold_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL rst_hold_valid got %b want 00", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_hold_ready got %b want 1", bus.in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL rst_valid got %b want 00", bus.out_valid); end
    n_cmp++; if (bus.out_instr0 !== 32'h0) begin n_err++; $display("FAIL rst_instr0 got %h want 0", bus.out_instr0); end
    n_cmp++; if (bus.out_pc1 !== 32'h0) begin n_err++; $display("FAIL rst_pc1 got %h want 0", bus.out_pc1); end
  endtask

  task automatic test_push_pop();
    bus.in_valid  = 2'b11;
    bus.in_instr0 = 32'h2010_0001;
    bus.in_pc0    = 32'h0000_0000;
    bus.in_instr1 = 32'h2011_0002;
    bus.in_pc1    = 32'h0000_0004;
    #1;
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL no_bypass got %b want 00", bus.out_valid); end
    @(posedge clk);
    #1;
    idle();
    n_cmp++; if (bus.count !== 4'd2) begin n_err++; $display("FAIL push2_count got %0d want 2", bus.count); end
    n_cmp++; if (bus.out_valid !== 2'b11) begin n_err++; $display("FAIL push2_valid got %b want 11", bus.out_valid); end
    n_cmp++; if (bus.out_pc0 !== 32'h0) begin n_err++; $display("FAIL push2_pc0 got %h want 0", bus.out_pc0); end
    n_cmp++; if (bus.out_pc1 !== 32'h4) begin n_err++; $display("FAIL push2_pc1 got %h want 4", bus.out_pc1); end
    n_cmp++; if (bus.out_instr0 !== 32'h2010_0001) begin n_err++; $display("FAIL push2_instr0 got %h want 20100001", bus.out_instr0); end
    n_cmp++; if (bus.out_instr1 !== 32'h2011_0002) begin n_err++; $display("FAIL push2_instr1 got %h want 20110002", bus.out_instr1); end
    drive(2'b00, 0, 0, 2'b01, 1'b0);
    n_cmp++; if (bus.out_pc0 !== 32'h4) begin n_err++; $display("FAIL pop1_pc0 got %h want 4", bus.out_pc0); end
    n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL pop1_count got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_valid !== 2'b01) begin n_err++; $display("FAIL pop1_valid got %b want 01", bus.out_valid); end
    n_cmp++; if (bus.out_instr0 !== 32'h2011_0002) begin n_err++; $display("FAIL pop1_instr0 got %h want 20110002", bus.out_instr0); end
    // Pop of two with only one present is ignored entirely.
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL overpop_count got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h4) begin n_err++; $display("FAIL overpop_pc0 got %h want 4", bus.out_pc0); end
    drive(2'b00, 0, 0, 2'b01, 1'b0); // empty: head=2 tail=2
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d got %b want 1", i, bus.in_ready); end
      drive(2'b11, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 2'b00, 1'b0);
    end
    n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_count got %0d want 8", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
    drive(2'b11, 32'h40, 32'h44, 2'b00, 1'b0);
    n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_ignore_count got %0d want 8", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h100) begin n_err++; $display("FAIL full_ignore_pc0 got %h want 100", bus.out_pc0); end
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    n_cmp++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL full_pop_count got %0d want 6", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_pc0 !== 32'h108) begin n_err++; $display("FAIL full_pop_pc0 got %h want 108", bus.out_pc0); end
    n_cmp++; if (bus.out_pc1 !== 32'h10c) begin n_err++; $display("FAIL full_pop_pc1 got %h want 10c", bus.out_pc1); end
  endtask

  task automatic test_wrap();
    drive(2'b00, 0, 0, 2'b00, 1'b1); // head=tail=0
    drive(2'b11, 32'h200, 32'h204, 2'b00, 1'b0);
    drive(2'b11, 32'h208, 32'h20c, 2'b00, 1'b0);
    drive(2'b11, 32'h210, 32'h214, 2'b00, 1'b0);
    drive(2'b01, 32'h218, 32'h0,   2'b00, 1'b0); // tail=7, count=7
    repeat (3) drive(2'b00, 0, 0, 2'b11, 1'b0);  // head=6, count=1
    n_cmp++; if (bus.out_pc0 !== 32'h218) begin n_err++; $display("FAIL wrap_pre_pc0 got %h want 218", bus.out_pc0); end
    drive(2'b11, 32'h80, 32'h84, 2'b00, 1'b0);   // lands at indices 7 and 0
    n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL wrap_push_count got %0d want 3", bus.count); end
    n_cmp++; if (bus.out_pc1 !== 32'h80) begin n_err++; $display("FAIL wrap_push_pc1 got %h want 80", bus.out_pc1); end
    drive(2'b00, 0, 0, 2'b01, 1'b0);             // head=7
    n_cmp++; if (bus.out_pc0 !== 32'h80) begin n_err++; $display("FAIL wrap_rd_pc0 got %h want 80", bus.out_pc0); end
    n_cmp++; if (bus.out_pc1 !== 32'h84) begin n_err++; $display("FAIL wrap_rd_pc1 got %h want 84", bus.out_pc1); end
    n_cmp++; if (bus.out_instr1 !== 32'h1300_0084) begin n_err++; $display("FAIL wrap_rd_instr1 got %h want 13000084", bus.out_instr1); end
    drive(2'b00, 0, 0, 2'b11, 1'b0);             // head=1, empty
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL wrap_pop_valid got %b want 00", bus.out_valid); end
    n_cmp++; if (bus.out_pc0 !== 32'h204) begin n_err++; $display("FAIL wrap_stale_pc0 got %h want 204", bus.out_pc0); end
  endtask

  task automatic test_back_to_back();
    drive(2'b11, 32'h300, 32'h304, 2'b00, 1'b0); // idx 1,2
    drive(2'b11, 32'h308, 32'h30c, 2'b00, 1'b0); // idx 3,4; count=4
    drive(2'b11, 32'h310, 32'h314, 2'b11, 1'b0); // idx 5,6; head=3
    n_cmp++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL b2b_count got %0d want 4", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h308) begin n_err++; $display("FAIL b2b_pc0 got %h want 308", bus.out_pc0); end
    drive(2'b11, 32'h318, 32'h31c, 2'b00, 1'b0); // idx 7,0; count=6
    drive(2'b11, 32'h320, 32'h324, 2'b01, 1'b0); // idx 1,2; head=4
    n_cmp++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL b2b_edge_count got %0d want 7", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h30c) begin n_err++; $display("FAIL b2b_edge_pc0 got %h want 30c", bus.out_pc0); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_edge_ready got %b want 0", bus.in_ready); end
    drive(2'b11, 32'h400, 32'h404, 2'b01, 1'b0); // push refused, pop taken
    n_cmp++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL b2b_refuse_count got %0d want 6", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h310) begin n_err++; $display("FAIL b2b_refuse_pc0 got %h want 310", bus.out_pc0); end
    drive(2'b10, 32'h500, 32'h504, 2'b10, 1'b0); // both illegal encodings ignored
    n_cmp++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL illegal_count got %0d want 6", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h310) begin n_err++; $display("FAIL illegal_pc0 got %h want 310", bus.out_pc0); end
  endtask

  task automatic test_flush();
    drive(2'b00, 0, 0, 2'b01, 1'b0);             // count=5
    n_cmp++; if (bus.count !== 4'd5) begin n_err++; $display("FAIL pre_flush_count got %0d want 5", bus.count); end
    drive(2'b11, 32'h600, 32'h604, 2'b11, 1'b1);
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid got %b want 00", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_pc0 !== 32'h31c) begin n_err++; $display("FAIL flush_keep_pc0 got %h want 31c", bus.out_pc0); end
    n_cmp++; if (bus.out_pc1 !== 32'h320) begin n_err++; $display("FAIL flush_keep_pc1 got %h want 320", bus.out_pc1); end
    drive(2'b01, 32'h500, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (bus.out_valid !== 2'b01) begin n_err++; $display("FAIL post_flush_valid got %b want 01", bus.out_valid); end
    n_cmp++; if (bus.out_pc0 !== 32'h500) begin n_err++; $display("FAIL post_flush_pc0 got %h want 500", bus.out_pc0); end
  endtask

  task automatic test_async_reset();
    drive(2'b11, 32'h504, 32'h508, 2'b00, 1'b0); // count=3
    n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL pre_arst_count got %0d want 3", bus.count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 2'b00) begin n_err++; $display("FAIL arst_valid got %b want 00", bus.out_valid); end
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_pc0 !== 32'h0) begin n_err++; $display("FAIL arst_pc0 got %h want 0", bus.out_pc0); end
    #1 rst_n = 1'b1;
    drive(2'b11, 32'h700, 32'h704, 2'b00, 1'b0);
    n_cmp++; if (bus.count !== 4'd2) begin n_err++; $display("FAIL post_arst_count got %0d want 2", bus.count); end
    n_cmp++; if (bus.out_pc0 !== 32'h700) begin n_err++; $display("FAIL post_arst_pc0 got %h want 700", bus.out_pc0); end
    n_cmp++; if (bus.out_pc1 !== 32'h704) begin n_err++; $display("FAIL post_arst_pc1 got %h want 704", bus.out_pc1); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_push_pop();
    test_full();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
